// File: rtl/gray_sum_stage_pkg.sv
// Shared types and constants for the gray summation stage.
package gray_sum_stage_pkg;

    // Sequencer states: wait for three products, two adds, one settle cycle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD1 = 2'd1,
        ST_ADD2 = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [31:0] FP_INF  = 32'h7F80_0000;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;

    localparam logic [EXP_W-1:0] EXP_ZERO = 8'h00;
    localparam logic [EXP_W-1:0] EXP_MAX  = 8'hFF;

endpackage

// File: rtl/fp_add_pos.sv
// Combinational single-precision adder for non-negative operands.
// Signs are ignored, denormals flush to zero, rounding truncates, and any
// infinite/NaN operand or exponent overflow saturates to +inf with ovf set.
module fp_add_pos
    import gray_sum_stage_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum,
    output logic        ovf
);

    logic [EXP_W-1:0]  exp_a_s;
    logic [EXP_W-1:0]  exp_b_s;
    logic              a_big_s;
    logic [EXP_W-1:0]  exp_big_s;
    logic [EXP_W-1:0]  exp_small_s;
    logic [MANT_W:0]   mant_big_s;
    logic [MANT_W:0]   mant_small_s;
    logic [EXP_W-1:0]  exp_diff_s;
    logic [MANT_W:0]   mant_shift_s;
    logic [MANT_W+1:0] mant_sum_s;
    logic [EXP_W:0]    exp_norm_s;
    logic [MANT_W:0]   mant_norm_s;
    logic              unused_s;

    assign exp_a_s = a[30:23];
    assign exp_b_s = b[30:23];

    // Sign bits and the normalised hidden bit never reach the result.
    assign unused_s = ^{a[31], b[31], mant_norm_s[MANT_W]};

    // Order operands by exponent and align the smaller mantissa.
    always_comb begin
        a_big_s      = (exp_a_s >= exp_b_s);
        exp_big_s    = exp_b_s;
        exp_small_s  = exp_a_s;
        mant_big_s   = {1'b1, b[22:0]};
        mant_small_s = {1'b1, a[22:0]};
        if (a_big_s) begin
            exp_big_s    = exp_a_s;
            exp_small_s  = exp_b_s;
            mant_big_s   = {1'b1, a[22:0]};
            mant_small_s = {1'b1, b[22:0]};
        end else begin
            exp_big_s    = exp_b_s;
            exp_small_s  = exp_a_s;
        end
        exp_diff_s = exp_big_s - exp_small_s;
        // A shift of 24 or more pushes every bit out: contribution is zero.
        if (exp_diff_s >= 8'd24) begin
            mant_shift_s = 24'd0;
        end else begin
            mant_shift_s = mant_small_s >> exp_diff_s;
        end
        mant_sum_s = {1'b0, mant_big_s} + {1'b0, mant_shift_s};
        // Carry out renormalises by one place; the dropped LSB is truncated.
        if (mant_sum_s[MANT_W+1]) begin
            exp_norm_s  = {1'b0, exp_big_s} + 9'd1;
            mant_norm_s = mant_sum_s[MANT_W+1:1];
        end else begin
            exp_norm_s  = {1'b0, exp_big_s};
            mant_norm_s = mant_sum_s[MANT_W:0];
        end
    end

    // Pick the special-case or normal result.
    always_comb begin
        sum = FP_ZERO;
        ovf = 1'b0;
        if ((exp_a_s == EXP_MAX) || (exp_b_s == EXP_MAX)) begin
            sum = FP_INF;
            ovf = 1'b1;
        end else if (exp_a_s == EXP_ZERO) begin
            sum = {1'b0, b[30:0]};
        end else if (exp_b_s == EXP_ZERO) begin
            sum = {1'b0, a[30:0]};
        end else if (exp_norm_s >= {1'b0, EXP_MAX}) begin
            sum = FP_INF;
            ovf = 1'b1;
        end else begin
            sum = {1'b0, exp_norm_s[EXP_W-1:0], mant_norm_s[MANT_W-1:0]};
        end
    end

endmodule

// File: rtl/gray_sum_stage.sv
// Final RGB-to-gray stage: captures three weighted channel products as their
// flags arrive, then sums (R+G)+B on one shared adder over two cycles.
module gray_sum_stage
    import gray_sum_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] Red_In,
    input  logic [DATA_W-1:0] Green_In,
    input  logic [DATA_W-1:0] Blue_In,
    input  logic              Flag_Red,
    input  logic              Flag_Green,
    input  logic              Flag_Blue,
    output logic [DATA_W-1:0] Gray_Out,
    output logic              Gray_Valid,
    output logic              Busy,
    output logic              Overflow
);

    state_e            state_r;
    state_e            state_nxt_s;
    logic [2:0]        cap_r;
    logic [2:0]        cap_nxt_s;
    logic [DATA_W-1:0] red_hold_r;
    logic [DATA_W-1:0] green_hold_r;
    logic [DATA_W-1:0] blue_hold_r;
    logic [DATA_W-1:0] acc_r;
    logic [DATA_W-1:0] gray_out_r;
    logic              gray_valid_r;
    logic              busy_r;
    logic              overflow_r;
    logic [DATA_W-1:0] op_a_s;
    logic [DATA_W-1:0] op_b_s;
    logic [DATA_W-1:0] sum_s;
    logic              ovf_s;

    // Capture bits as they would stand after this edge in IDLE.
    assign cap_nxt_s = cap_r | {Flag_Blue, Flag_Green, Flag_Red};

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cap_nxt_s == 3'b111) begin
                    state_nxt_s = ST_ADD1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ADD1: state_nxt_s = ST_ADD2;
            ST_ADD2: state_nxt_s = ST_DONE;
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Steer the shared adder: R+G in ADD1, acc+B otherwise.
    always_comb begin
        op_a_s = acc_r;
        op_b_s = blue_hold_r;
        if (state_r == ST_ADD1) begin
            op_a_s = red_hold_r;
            op_b_s = green_hold_r;
        end else begin
            op_a_s = acc_r;
            op_b_s = blue_hold_r;
        end
    end

    fp_add_pos u_fp_add (
        .a   (op_a_s),
        .b   (op_b_s),
        .sum (sum_s),
        .ovf (ovf_s)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Latch each product once per result; flags outside IDLE are dropped.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cap_r        <= 3'b000;
            red_hold_r   <= FP_ZERO;
            green_hold_r <= FP_ZERO;
            blue_hold_r  <= FP_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (Flag_Red && !cap_r[0]) begin
                        red_hold_r <= Red_In;
                    end
                    if (Flag_Green && !cap_r[1]) begin
                        green_hold_r <= Green_In;
                    end
                    if (Flag_Blue && !cap_r[2]) begin
                        blue_hold_r <= Blue_In;
                    end
                    cap_r <= cap_nxt_s;
                end
                ST_DONE: cap_r <= 3'b000;
                default: cap_r <= cap_r;
            endcase
        end
    end

    // Accumulator, result, flags and busy indication.
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_r        <= FP_ZERO;
            gray_out_r   <= FP_ZERO;
            gray_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s != ST_IDLE);
            case (state_r)
                ST_ADD1: begin
                    acc_r        <= sum_s;
                    gray_valid_r <= 1'b0;
                end
                ST_ADD2: begin
                    // A saturated first add leaves acc at +inf, which the
                    // second add flags again, so ovf_s covers both adds.
                    gray_out_r   <= sum_s;
                    overflow_r   <= ovf_s;
                    gray_valid_r <= 1'b1;
                end
                default: gray_valid_r <= 1'b0;
            endcase
        end
    end

    assign Gray_Out   = gray_out_r;
    assign Gray_Valid = gray_valid_r;
    assign Busy       = busy_r;
    assign Overflow   = overflow_r;

endmodule

// File: tb/tb_gray_sum_stage.sv
// Scoreboard bench for gray_sum_stage: directed product triples with
// hand-computed sums are queued as they are issued; a monitor checks each
// Gray_Valid pulse against the queue head, including its arrival cycle.
module tb_gray_sum_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] Red_In, Green_In, Blue_In;
    logic        Flag_Red, Flag_Green, Flag_Blue;
    logic [31:0] Gray_Out;
    logic        Gray_Valid, Busy, Overflow;

    typedef struct {
        logic [31:0] data;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    gray_sum_stage #(.DATA_W(32)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Red_In     (Red_In),
        .Green_In   (Green_In),
        .Blue_In    (Blue_In),
        .Flag_Red   (Flag_Red),
        .Flag_Green (Flag_Green),
        .Flag_Blue  (Flag_Blue),
        .Gray_Out   (Gray_Out),
        .Gray_Valid (Gray_Valid),
        .Busy       (Busy),
        .Overflow   (Overflow)
    );

    always #5 CLK = ~CLK;

    // Edge counter: after rising edge N it reads N.
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: actual=%08h required=%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Queue a result; called at the negedge before the edge that samples the
    // last flag, so Gray_Valid is expected after that edge plus two.
    task automatic push_exp(input logic [31:0] data, input logic ovf);
        exp_t e;
        e.data = data;
        e.ovf  = ovf;
        e.cyc  = cyc + 3;
        exp_q.push_back(e);
    endtask

    // Present data with the given flags for one edge, then drop the flags.
    task automatic drive(input logic fr, input logic fg, input logic fb,
                         input logic [31:0] r, input logic [31:0] g, input logic [31:0] b);
        Red_In     = r;
        Green_In   = g;
        Blue_In    = b;
        Flag_Red   = fr;
        Flag_Green = fg;
        Flag_Blue  = fb;
        @(negedge CLK);
        Flag_Red   = 1'b0;
        Flag_Green = 1'b0;
        Flag_Blue  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Wait (bounded) for all queued results, then let the FSM return to IDLE.
    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            @(negedge CLK);
            k++;
        end
        check(exp_q.size() == 0, "drain_timeout", exp_q.size(), 32'd0);
        idle(2);
    endtask

    // Monitor: every valid pulse must match the queue head, value and cycle.
    always @(negedge CLK) begin
        exp_t e;
        if (Gray_Valid) begin
            check(exp_q.size() != 0, "unexpected_valid", Gray_Out, 32'd0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check(Gray_Out === e.data, "gray_out", Gray_Out, e.data);
                check(Overflow === e.ovf, "overflow", {31'd0, Overflow}, {31'd0, e.ovf});
                check(cyc == e.cyc, "latency_cycle", cyc, e.cyc);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        RST = 1'b1;
        Red_In = 32'h0; Green_In = 32'h0; Blue_In = 32'h0;
        Flag_Red = 1'b0; Flag_Green = 1'b0; Flag_Blue = 1'b0;
        idle(2);
        check(Gray_Out == 32'h0, "reset_gray_out", Gray_Out, 32'h0);
        check(Gray_Valid == 1'b0, "reset_gray_valid", {31'd0, Gray_Valid}, 32'd0);
        check(Busy == 1'b0, "reset_busy", {31'd0, Busy}, 32'd0);
        check(Overflow == 1'b0, "reset_overflow", {31'd0, Overflow}, 32'd0);
        RST = 1'b0;
        idle(1);

        // Basic sum 1 + 2 + 4 = 7, all flags together.
        push_exp(32'h40E0_0000, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 32'h3F80_0000, 32'h4000_0000, 32'h4080_0000);
        check(Busy == 1'b1, "busy_in_add1", {31'd0, Busy}, 32'd1);
        drain();

        // Staggered: B=0 at t0, R=1.5 at t0+2, G=1.5 at t0+5 -> 3.0.
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0000_0000);
        idle(1);
        drive(1'b1, 1'b0, 1'b0, 32'h3FC0_0000, 32'h0, 32'h0);
        check(Busy == 1'b0, "busy_partial_capture", {31'd0, Busy}, 32'd0);
        idle(2);
        push_exp(32'h4040_0000, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h3FC0_0000, 32'h0);
        drain();

        // Alignment drop and truncation: 2^24 + 1 + 1 = 2^24.
        push_exp(32'h4B80_0000, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 32'h4B80_0000, 32'h3F80_0000, 32'h3F80_0000);
        drain();

        // Overflow, then a normal result clears it.
        push_exp(32'h7F80_0000, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 32'h7F00_0000, 32'h7F00_0000, 32'h0000_0000);
        drain();
        push_exp(32'h40E0_0000, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 32'h3F80_0000, 32'h4000_0000, 32'h4080_0000);
        drain();

        // Duplicate red flag keeps 2.0 (not 8.0): 2 + 1 + 4 = 7.
        drive(1'b1, 1'b0, 1'b0, 32'h4000_0000, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h4100_0000, 32'h0, 32'h0);
        push_exp(32'h40E0_0000, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 32'h0, 32'h3F80_0000, 32'h4080_0000);
        // Flags held through ADD1/ADD2/DONE are ignored: no second result.
        Red_In = 32'h4120_0000; Green_In = 32'h4120_0000; Blue_In = 32'h4120_0000;
        Flag_Red = 1'b1; Flag_Green = 1'b1; Flag_Blue = 1'b1;
        idle(3);
        Flag_Red = 1'b0; Flag_Green = 1'b0; Flag_Blue = 1'b0;
        drain();
        idle(4);
        check(Busy == 1'b0, "busy_after_ignored_flags", {31'd0, Busy}, 32'd0);

        // Reset while in ADD2 cancels the result.
        drive(1'b1, 1'b1, 1'b1, 32'h3F80_0000, 32'h4000_0000, 32'h4080_0000);
        idle(1);
        RST = 1'b1;
        idle(1);
        RST = 1'b0;
        check(Gray_Valid == 1'b0, "rst_mid_valid", {31'd0, Gray_Valid}, 32'd0);
        check(Gray_Out == 32'h0, "rst_mid_gray_out", Gray_Out, 32'h0);
        check(Busy == 1'b0, "rst_mid_busy", {31'd0, Busy}, 32'd0);
        idle(3);
        check(Gray_Out == 32'h0, "rst_mid_no_late_result", Gray_Out, 32'h0);

        // Recovery: 1 + 1 + 2 = 4.
        push_exp(32'h4080_0000, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
        drain();

        idle(3);
        check(exp_q.size() == 0, "leftover_expected", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
